pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder.sv | 103 ++++++++++
 tb/tb_pipelined_adder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Carry-pipelined adder: one WIDTH/STAGES-bit slice per stage, valid/ready handshake on both sides.
// Optional signed-overflow output is enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
`ifdef PIPELINED_ADDER_OVF_EN
  output logic             out_ovf,
`endif
  output logic             out_cout
);

  localparam int S = WIDTH / STAGES;

  if (WIDTH % STAGES != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  logic             adv;
  logic [STAGES:0]  vld_q;
  logic [STAGES:0]  c_q;
  logic [STAGES:0]  c_nxt;
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES+1];
  logic [WIDTH-1:0] s_nxt [STAGES+1];
  logic [S:0]       part_sum [STAGES];

  // Level 0 registers the raw operands; level k+1 holds slices 0..k of the sum.
  assign adv       = !vld_q[STAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES];
  assign out_sum   = s_q[STAGES];
  assign out_cout  = c_q[STAGES];

  always_comb begin
    s_nxt[0] = '0;
    c_nxt    = '0;
    c_nxt[0] = cin;
    for (int k = 0; k < STAGES; k++) begin
      part_sum[k] = {1'b0, a_q[k][k*S +: S]} + {1'b0, b_q[k][k*S +: S]}
                  + {{S{1'b0}}, c_q[k]};
      s_nxt[k+1]            = s_q[k];
      s_nxt[k+1][k*S +: S]  = part_sum[k][S-1:0];
      c_nxt[k+1]            = part_sum[k][S];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      c_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int k = 0; k <= STAGES; k++) begin
        s_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q  <= {vld_q[STAGES-1:0], in_valid};
      c_q    <= c_nxt;
      a_q[0] <= in1;
      b_q[0] <= in2;
      for (int k = 1; k < STAGES; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
      for (int k = 0; k <= STAGES; k++) begin
        s_q[k] <= s_nxt[k];
      end
    end
  end

`ifdef PIPELINED_ADDER_OVF_EN
  logic msb_a_q;
  logic msb_b_q;

  // Operand MSBs leave the last operand level together with the final slice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msb_a_q <= 1'b0;
      msb_b_q <= 1'b0;
    end else if (adv) begin
      msb_a_q <= a_q[STAGES-1][WIDTH-1];
      msb_b_q <= b_q[STAGES-1][WIDTH-1];
    end
  end

  assign out_ovf = (msb_a_q == msb_b_q) && (out_sum[WIDTH-1] != msb_a_q);
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=32, STAGES=4); expected results come from
// plain 33-bit / signed arithmetic on the accepted operands.
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  int n_out = 0;

  logic [33:0] sb [$];
  logic        stall_prev = 1'b0;
  logic [33:0] hold = '0;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
`ifdef PIPELINED_ADDER_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .out_cout  (out_cout)
  );

`ifndef PIPELINED_ADDER_OVF_EN
  assign out_ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic c);
    logic [32:0] w;
    longint      sr;
    logic        ov;
    w  = {1'b0, a} + {1'b0, b} + {32'd0, c};
    sr = longint'($signed(a)) + longint'($signed(b)) + (c ? 64'sd1 : 64'sd0);
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`ifndef PIPELINED_ADDER_OVF_EN
    ov = 1'b0;
`endif
    return {ov, w};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus side of the scoreboard: an accepting edge follows this negedge.
  always @(negedge clk) begin
    if (rst === 1'b0 && in_valid && in_ready) begin
      sb.push_back(ref_add(in1, in2, cin));
      n_acc++;
    end
  end

  // Output side: pop on every transfer, check hold under stall and the ready rule.
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_hold_valid", 64'(out_valid), 64'd1);
        chk("stall_hold_data", 64'({out_ovf, out_cout, out_sum}), 64'(hold));
      end
      chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("out_with_empty_sb", 64'(out_valid), 64'd0);
        else chk("result", 64'({out_ovf, out_cout, out_sum}), 64'(sb.pop_front()));
        n_out++;
      end
      stall_prev = out_valid && !out_ready;
      hold       = {out_ovf, out_cout, out_sum};
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] hist;
    logic        found;
    int          quiet_hits;
    int          base;
    int          cyc;

    rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; cin = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum",   64'(out_sum),   64'd0);
    chk("rst_out_cout",  64'(out_cout),  64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
`ifdef PIPELINED_ADDER_OVF_EN
    chk("rst_out_ovf",   64'(out_ovf),   64'd0);
`endif

    // First edge after release accepts; result valid exactly 4 edges later.
    rst = 1'b0; in_valid = 1'b1; in1 = 32'hFFFF_FFFF; in2 = 32'h1; cin = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("lat_0", 64'(out_valid), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("lat_%0d", i), 64'(out_valid), 64'(i == 4));
    end
    chk("wrap_sum",  64'(out_sum),  64'd0);
    chk("wrap_cout", 64'(out_cout), 64'd1);
    tick();

    // Eight back-to-back operations must come out as eight consecutive valids.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in1 = $urandom; in2 = $urandom; cin = i[0];
      tick();
      hist[i] = out_valid;
    end
    in_valid = 1'b0;
    for (int i = 8; i < 16; i++) begin
      tick();
      hist[i] = out_valid;
    end
    chk("b2b_valid_pattern", 64'(hist), 64'h0FF0);

    // Stall for 5 cycles with 0x12345678+0x11111111 at the output.
    in_valid = 1'b1; in1 = 32'h1234_5678; in2 = 32'h1111_1111; cin = 1'b0;
    tick();
    in1 = 32'h1; in2 = 32'h2;
    tick();
    in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (out_valid) found = 1'b1;
      else tick();
    end
    chk("stall_reach", 64'(found), 64'd1);
    out_ready = 1'b0;
    in_valid = 1'b1; in1 = $urandom; in2 = $urandom;
    chk("stall_sum_first", 64'(out_sum), 64'h2345_6789);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid",    64'(out_valid), 64'd1);
      chk("stall_sum",      64'(out_sum),   64'h2345_6789);
      chk("stall_in_ready", 64'(in_ready),  64'd0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (6) tick();
    chk("stall_drained", 64'(sb.size()), 64'd0);

    // Overflow / carry corner pair.
    in_valid = 1'b1; in1 = 32'h7FFF_FFFF; in2 = 32'h1; cin = 1'b0;
    tick();
    in1 = 32'hFFFF_FFFF;
    tick();
    in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (out_valid) found = 1'b1;
      else tick();
    end
    chk("ovf_reach", 64'(found), 64'd1);
    chk("ovf_case1_sum",  64'(out_sum),  64'h8000_0000);
    chk("ovf_case1_cout", 64'(out_cout), 64'd0);
`ifdef PIPELINED_ADDER_OVF_EN
    chk("ovf_case1_ovf",  64'(out_ovf),  64'd1);
`endif
    tick();
    chk("ovf_case2_cout", 64'(out_cout), 64'd1);
`ifdef PIPELINED_ADDER_OVF_EN
    chk("ovf_case2_ovf",  64'(out_ovf),  64'd0);
`endif
    repeat (4) tick();

    // Reset with three operations in flight discards them all.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in1 = $urandom; in2 = $urandom; cin = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_sum",   64'(out_sum),   64'd0);
    chk("midrst_out_cout",  64'(out_cout),  64'd0);
    chk("midrst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    quiet_hits = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) quiet_hits++;
    end
    chk("post_rst_quiet", 64'(quiet_hits), 64'd0);

    // Random traffic with random backpressure.
    base = n_acc;
    cyc  = 0;
    while ((n_acc - base) < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in1       = pick();
      in2       = pick();
      cin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
      cyc++;
    end
    chk("random_accepted", 64'((n_acc - base) >= 10000), 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (sb.size() > 0 && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
